// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial bit-pattern detector.
// Shifts one qualified bit per cycle into a history register and pulses
// seq_detected (registered) when the newest len bits equal the loaded pattern.
// Overlapping or non-overlapping detection is chosen per cycle by 'overlap'.
// Optional feature macro: SEQDET_COUNT_EN adds a saturating match_count output.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         overlap,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  output logic                         armed,
  output logic                         cfg_err,
  output logic                         seq_detected
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]             match_count
`endif
);

  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [LW-1:0] LEN_MIN  = LW'(2);
  localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] FILL_ONE = LW'(1);
  localparam logic [LW-1:0] FILL_ZERO = LW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t               state_r, state_n_s;
  logic [MAX_LEN-1:0]   hist_r, hist_n_s;
  logic [MAX_LEN-1:0]   pat_r, pat_n_s;
  logic [LW-1:0]        len_r, len_n_s;
  logic [LW-1:0]        fill_r, fill_n_s;
  logic                 armed_r, cfg_err_r, det_r;
  logic                 err_n_s, det_n_s;

  logic                 accept_s;
  logic                 cfg_legal_s;
  logic [MAX_LEN-1:0]   hist_shift_s;
  logic [LW-1:0]        fill_inc_s;
  logic [MAX_LEN-1:0]   len_mask_s;
  logic                 match_s;

  // Datapath helpers: acceptance, shifted history, saturating fill and match test.
  always_comb begin
    accept_s     = in_valid && !cfg_load && (state_r != ST_IDLE);
    cfg_legal_s  = (cfg_len >= LEN_MIN) && (cfg_len <= FILL_MAX);
    hist_shift_s = {hist_r[MAX_LEN-2:0], in_bit};
    if (fill_r == FILL_MAX) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + FILL_ONE;
    end
    len_mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask_s[i] = (i < int'(len_r));
    end
    match_s = accept_s
              && (((hist_shift_s ^ pat_r) & len_mask_s) == {MAX_LEN{1'b0}})
              && (fill_inc_s >= len_r);
  end

  // Next-state logic: configuration loads take priority over stream bits.
  always_comb begin
    state_n_s = state_r;
    hist_n_s  = hist_r;
    fill_n_s  = fill_r;
    pat_n_s   = pat_r;
    len_n_s   = len_r;
    err_n_s   = 1'b0;
    det_n_s   = 1'b0;
    if (cfg_load) begin
      if (cfg_legal_s) begin
        pat_n_s   = cfg_pattern;
        len_n_s   = cfg_len;
        hist_n_s  = {MAX_LEN{1'b0}};
        fill_n_s  = FILL_ZERO;
        state_n_s = ST_FILL;
      end else begin
        state_n_s = ST_IDLE;
        err_n_s   = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n_s = ST_IDLE;
        end
        ST_FILL, ST_RUN: begin
          if (accept_s) begin
            hist_n_s = hist_shift_s;
            fill_n_s = fill_inc_s;
            det_n_s  = match_s;
            if (match_s && !overlap) begin
              // Non-overlap: the matched bits may not seed the next match.
              fill_n_s  = FILL_ZERO;
              state_n_s = ST_FILL;
            end else if (fill_inc_s >= len_r) begin
              state_n_s = ST_RUN;
            end else begin
              state_n_s = ST_FILL;
            end
          end else begin
            state_n_s = state_r;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      hist_r    <= {MAX_LEN{1'b0}};
      fill_r    <= FILL_ZERO;
      pat_r     <= {MAX_LEN{1'b0}};
      len_r     <= FILL_ZERO;
      armed_r   <= 1'b0;
      cfg_err_r <= 1'b0;
      det_r     <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      hist_r    <= hist_n_s;
      fill_r    <= fill_n_s;
      pat_r     <= pat_n_s;
      len_r     <= len_n_s;
      armed_r   <= (state_n_s != ST_IDLE);
      cfg_err_r <= err_n_s;
      det_r     <= det_n_s;
    end
  end

  assign armed        = armed_r;
  assign cfg_err      = cfg_err_r;
  assign seq_detected = det_r;

`ifdef SEQDET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Saturating match counter, cleared by reset and by any configuration load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (match_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_count = cnt_r;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               overlap = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               armed, cfg_err, seq_detected;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  int total = 0;
  int bad   = 0;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .overlap     (overlap),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .seq_detected(seq_detected)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input string tag, input logic b, input logic exp_det);
    in_valid = 1'b1; in_bit = b;
    tick();
    in_valid = 1'b0;
    chk(tag, seq_detected, exp_det);
  endtask

  task automatic bubble(input string tag);
    in_valid = 1'b0;
    tick();
    chk(tag, seq_detected, 1'b0);
  endtask

  // Send a stream (first bit at index n-1) checking the pulse after each bit.
  task automatic stream(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      send(tag, bits[i], exp[i]);
    end
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_armed", armed, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_det", seq_detected, 1'b0);

    // 0110 non-overlap: only one pulse after bit 4
    overlap = 1'b0;
    load(8'b0110, 4'd4);
    chk("load_armed", armed, 1'b1);
    chk("load_err", cfg_err, 1'b0);
    stream("p0110_novl", 7, 16'b0110110, 16'b0001000);

    // 0110 overlap: pulses after bits 4 and 7
    overlap = 1'b1;
    load(8'b0110, 4'd4);
    stream("p0110_ovl", 7, 16'b0110110, 16'b0001001);
`ifdef SEQDET_COUNT_EN
    chk("cnt_0110", match_count, 2);
`endif

    // 1010 overlap then non-overlap
    load(8'b1010, 4'd4);
    stream("p1010_ovl", 6, 16'b101010, 16'b000101);
    overlap = 1'b0;
    load(8'b1010, 4'd4);
    stream("p1010_novl", 6, 16'b101010, 16'b000100);

    // Illegal lengths
    load(8'b1, 4'd1);
    chk("len1_err", cfg_err, 1'b1);
    chk("len1_armed", armed, 1'b0);
    tick();
    chk("err_pulse_end", cfg_err, 1'b0);
    load(8'hFF, 4'd9);
    chk("len9_err", cfg_err, 1'b1);
    chk("len9_armed", armed, 1'b0);
    send("idle_ignore", 1'b1, 1'b0);
    load(8'b111, 4'd3);
    chk("p111_armed", armed, 1'b1);
    chk("p111_err", cfg_err, 1'b0);
    stream("p111", 3, 16'b111, 16'b001);

    // Reset mid-pattern
    load(8'b101, 4'd3);
    stream("p101_pre", 2, 16'b10, 16'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_armed", armed, 1'b0);
    chk("midrst_det", seq_detected, 1'b0);
    send("post_rst", 1'b1, 1'b0);
    chk("post_rst_armed", armed, 1'b0);

    // Bubbles do not disturb the history
    load(8'b101, 4'd3);
    send("bub_b1", 1'b1, 1'b0);
    bubble("bub_g1");
    bubble("bub_g2");
    send("bub_b2", 1'b0, 1'b0);
    bubble("bub_g3");
    send("bub_b3", 1'b1, 1'b1);
    bubble("bub_end");

    // 11 overlap: 8 ones give 7 pulses, counter saturates at 3
    overlap = 1'b1;
    load(8'b11, 4'd2);
    stream("p11_ovl", 8, 16'hFF, 16'h7F);
`ifdef SEQDET_COUNT_EN
    chk("cnt_sat", match_count, 3);
`endif

    // Load with a simultaneous valid bit: bit is dropped
    in_valid = 1'b1; in_bit = 1'b1;
    load(8'b11, 4'd2);
    in_valid = 1'b0;
    chk("ld_drop_det", seq_detected, 1'b0);
`ifdef SEQDET_COUNT_EN
    chk("cnt_clr", match_count, 0);
`endif
    send("ld_drop_b1", 1'b1, 1'b0);
    send("ld_drop_b2", 1'b1, 1'b1);
`ifdef SEQDET_COUNT_EN
    chk("cnt_after", match_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
